valu_sequencer: RTL and testbench

VALU_SEQUENCER -- requirements
Module: valu_sequencer

---
 rtl/valu_sequencer.sv | 141 ++++++++++++++
 tb/tb_valu_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_sequencer.sv
// Vector ALU sequencer: one shared scalar alu walks the lanes of a latched
// vector operation, one lane per clock, then holds the result for a handshake.
module valu_sequencer #(
    parameter int dataSize = 8,
    parameter int lanes    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op_sel,
    input  logic [lanes*dataSize-1:0] vec_a,
    input  logic [lanes*dataSize-1:0] vec_b,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lanes*dataSize-1:0] vec_res,
    output logic [lanes-1:0]          zero_vec,
    output logic [lanes-1:0]          neg_vec,
    output logic                      busy
);

    localparam int cnt_w = $clog2(lanes);
    localparam logic [cnt_w-1:0] last_lane = cnt_w'(lanes - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    state_t                    next_state;
    logic [cnt_w-1:0]          cnt;
    logic [2:0]                op_q;
    logic [lanes*dataSize-1:0] a_q;
    logic [lanes*dataSize-1:0] b_q;
    logic [dataSize-1:0]       lane_a;
    logic [dataSize-1:0]       lane_b;
    logic [dataSize-1:0]       lane_res;
    logic                      lane_zero;
    logic                      lane_neg;
    logic                      accept;

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign lane_a    = a_q[cnt*dataSize +: dataSize];
    assign lane_b    = b_q[cnt*dataSize +: dataSize];
    assign lane_zero = (lane_res == '0);
    assign lane_neg  = (lane_a[dataSize-1] != lane_res[dataSize-1]) && !lane_zero;

    alu #(.dataSize(dataSize)) u_alu (
        .op     (op_q),
        .a      (lane_a),
        .b      (lane_b),
        .result (lane_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins over everything; a DONE handshake always returns to IDLE
    // so a new offer is only taken on a later edge.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) next_state = RUN;
                RUN:     if (cnt == last_lane) next_state = DONE;
                DONE:    if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            vec_res  <= '0;
            zero_vec <= '0;
            neg_vec  <= '0;
        end else if (flush) begin
            cnt      <= '0;
            vec_res  <= '0;
            zero_vec <= '0;
            neg_vec  <= '0;
        end else if (accept) begin
            cnt      <= '0;
            op_q     <= op_sel;
            a_q      <= vec_a;
            b_q      <= vec_b;
            vec_res  <= '0;
            zero_vec <= '0;
            neg_vec  <= '0;
        end else if (state == RUN) begin
            vec_res[cnt*dataSize +: dataSize] <= lane_res;
            zero_vec[cnt]                     <= lane_zero;
            neg_vec[cnt]                      <= lane_neg;
            // The counter parks on the last lane instead of wrapping.
            if (cnt != last_lane) begin
                cnt <= cnt + cnt_w'(1);
            end
        end
    end

endmodule

// Scalar ALU shared by all lanes; results wrap modulo 2^dataSize.
module alu #(
    parameter int dataSize = 8
) (
    input  logic [2:0]          op,
    input  logic [dataSize-1:0] a,
    input  logic [dataSize-1:0] b,
    output logic [dataSize-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            3'b001:  result = a ^ b;
            3'b010:  result = a + b;
            3'b011:  result = a - b;
            3'b100:  result = a * b;
            3'b101:  result = a >> b;
            3'b110:  result = a << b;
            3'b111:  result = a + dataSize'(16);
            default: result = '0;
        endcase
    end

endmodule

// File: tb/tb_valu_sequencer.sv
// Directed and randomized bench for valu_sequencer (dataSize=8, lanes=4)
// against an arithmetic lane model.
module tb_valu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_sel;
    logic [31:0] vec_a;
    logic [31:0] vec_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] vec_res;
    logic [3:0]  zero_vec;
    logic [3:0]  neg_vec;
    logic        busy;

    int pass_count  = 0;
    int check_count = 0;

    valu_sequencer #(.dataSize(8), .lanes(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_res   (vec_res),
        .zero_vec  (zero_vec),
        .neg_vec   (neg_vec),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Lane result straight from the operation table, using wide integers.
    function automatic logic [7:0] ref_lane(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            3'd1:    r = ai ^ bi;
            3'd2:    r = ai + bi;
            3'd3:    r = ai - bi;
            3'd4:    r = ai * bi;
            3'd5:    r = ai >> bi;
            3'd6:    r = ai << bi;
            3'd7:    r = ai + 16;
            default: r = 0;
        endcase
        return 8'(r & 255);
    endfunction

    task automatic check_idle_clear(input string tag);
        check_output({tag, "_busy"},      {31'd0, busy},      32'd0);
        check_output({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_output({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check_output({tag, "_vec_res"},   vec_res,            32'd0);
        check_output({tag, "_zero_vec"},  {28'd0, zero_vec},  32'd0);
        check_output({tag, "_neg_vec"},   {28'd0, neg_vec},   32'd0);
    endtask

    // Runs one full operation: accept, lane-by-lane progress, hold, handshake.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        logic [3:0]  exp_z;
        logic [3:0]  exp_n;
        logic [31:0] part_res;
        logic [3:0]  part_z;
        logic [3:0]  part_n;
        logic [7:0]  r;
        logic [7:0]  al;
        for (int i = 0; i < 4; i++) begin
            al = a[i*8 +: 8];
            r  = ref_lane(op, al, b[i*8 +: 8]);
            exp_res[i*8 +: 8] = r;
            exp_z[i] = (r == 8'd0);
            exp_n[i] = (al[7] != r[7]) && (r != 8'd0);
        end

        check_output("pre_accept_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_sel   = op;
        vec_a    = a;
        vec_b    = b;
        tick();
        // Scramble the inputs and keep offering; none of it may reach the result.
        op_sel = 3'($urandom_range(0, 7));
        vec_a  = $urandom;
        vec_b  = $urandom;

        for (int k = 1; k <= 4; k++) begin
            part_res = '0;
            part_z   = '0;
            part_n   = '0;
            for (int i = 0; i < k; i++) begin
                part_res[i*8 +: 8] = exp_res[i*8 +: 8];
                part_z[i] = exp_z[i];
                part_n[i] = exp_n[i];
            end
            tick();
            check_output($sformatf("lane%0d_out_valid", k), {31'd0, out_valid},
                         {31'd0, (k == 4)});
            check_output($sformatf("lane%0d_vec_res", k), vec_res, part_res);
            check_output($sformatf("lane%0d_zero_vec", k), {28'd0, zero_vec}, {28'd0, part_z});
            check_output($sformatf("lane%0d_neg_vec", k), {28'd0, neg_vec}, {28'd0, part_n});
            check_output($sformatf("lane%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end

        for (int h = 0; h < hold; h++) begin
            vec_a = $urandom;
            tick();
            check_output("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check_output("hold_in_ready",  {31'd0, in_ready},  32'd0);
            check_output("hold_vec_res",   vec_res,            exp_res);
            check_output("hold_flags",     {24'd0, zero_vec, neg_vec}, {24'd0, exp_z, exp_n});
        end

        // Handshake with a pending offer: only the handshake may happen.
        out_ready = 1'b1;
        tick();
        check_output("handshake_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("handshake_busy",      {31'd0, busy},      32'd0);
        check_output("handshake_in_ready",  {31'd0, in_ready},  32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sel    = 3'd0;
        vec_a     = '0;
        vec_b     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_idle_clear("reset");
        rst_n = 1'b1;
        tick();
        check_idle_clear("post_reset");

        $display("[TB] directed add and subtract");
        apply_stimulus(3'b010, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd10, 8'd20, 8'd30, 8'd40}, 1);
        apply_stimulus(3'b011, 32'h05801001, 32'h05012001, 5);

        $display("[TB] flush during multiply");
        check_output("pre_mul_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_sel   = 3'b100;
        vec_a    = 32'h07050302;
        vec_b    = 32'h09080706;
        tick();
        in_valid = 1'b0;
        tick();
        check_output("mul_running_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle_clear("flush");

        // Flush beats a simultaneous offer.
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle_clear("flush_vs_accept");

        apply_stimulus(3'b001, 32'hA5C30FF0, 32'h5A3C0F0F, 0);

        $display("[TB] asynchronous reset during run");
        in_valid = 1'b1;
        op_sel   = 3'b010;
        vec_a    = 32'h11223344;
        vec_b    = 32'h01010101;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_clear("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_clear("reset_release");
        for (int c = 0; c < 6; c++) begin
            tick();
            check_output("discarded_out_valid", {31'd0, out_valid}, 32'd0);
        end

        apply_stimulus(3'b111, 32'hF0F0F0F0, $urandom, 0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 12; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (rop == 3'b101 || rop == 3'b110) begin
                for (int i = 0; i < 4; i++) begin
                    rb[i*8 +: 8] = 8'($urandom_range(0, 9));
                end
            end
            apply_stimulus(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
